pkt_prio_sched: RTL and testbench
=================================

Name: pkt_prio_sched

Overview:
- Weighted round-robin scheduler behind the packet prioritiser.
- Accepts priority-tagged words (prior value 1..NUM_CLASS, one word per packet) into per-class FIFOs.
- Drains the FIFOs to a single valid/ready output using per-class configurable weights.
- Owns the shared egress port and throttles the prioritiser through per-class backpressure.

Parameters:
- DWIDTH, 32, data word width
- PRIOR_WIDTH, 6, width of the prior tag
- NUM_CLASS, 7, number of classes; class c serves prior value c+1
- QDEPTH, 4, per-class FIFO depth (power of two, >=2)
- WWIDTH, 4, per-class weight width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  input word can be taken this cycle
- in_prior  in  PRIOR_WIDTH  priority tag of input word
- in_data  in  DWIDTH  input word
- cfg_weight  in  NUM_CLASS*WWIDTH  weight of class c at bits [c*WWIDTH +: WWIDTH]
- out_valid  out  1  output word present
- out_ready  in  1  consumer takes word
- out_data  out  DWIDTH  output word
- out_prior  out  PRIOR_WIDTH  prior tag of output word
- drop_cnt  out  16  count of discarded input words (saturating)

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFOs empty; out_valid=0, out_data=0, out_prior=0, drop_cnt=0
  - service pointer=class 0, credit=0, FSM in IDLE
  - any packet in flight is lost; no partial output after release
- Input handshake = in_valid & in_ready.
  - Valid prior (1..NUM_CLASS): in_ready = !full[prior-1]; the word is written to that FIFO at the clock edge.
  - Invalid prior (0 or >NUM_CLASS): in_ready=1; the word is discarded and drop_cnt increments, saturating at 0xFFFF.
  - in_ready depends combinationally on in_prior only; there is no combinational path from out_ready.
  - A full FIFO deasserts in_ready even if the same FIFO pops this cycle (no bypass).
- Output register:
  - Loaded when (!out_valid | out_ready) and a class is selected; a load pops one word from the selected FIFO.
  - out_valid, out_data and out_prior stay stable while out_valid & !out_ready.
  - Latency: a word accepted in cycle t into an idle scheduler with an empty output register shows out_valid in cycle t+2.
- FSM:
  - IDLE: all FIFOs empty. On any FIFO non-empty, search round-robin from the pointer (ascending, wrapping at NUM_CLASS) for the first non-empty class. Set the pointer to it, credit = its weight (weight 0 treated as 1), go to SERVE.
  - SERVE: each pop decrements credit.
  - When credit reaches 0, or the current FIFO becomes empty after a pop, advance to the next non-empty class after the current one in the same cycle. Reload credit from cfg_weight at that moment; if no FIFO is non-empty, go to IDLE.
  - If the current FIFO is empty with credit remaining (no pop possible), advance the same way without waiting.
- cfg_weight is sampled only at credit load; changes mid-service take effect at the next class switch.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged.
- Pointers and counters wrap modulo QDEPTH; count width is log2(QDEPTH)+1.

Optional Feature:
- Macro PRIO_SCHED_STRICT_EN.
- Defined: class 0 (prior 1) is strict-priority.
  - Whenever FIFO 0 is non-empty at a load opportunity, it is popped ahead of the WRR selection.
  - Strict pops consume no credit and do not move the pointer.
  - Class 0 is excluded from WRR rotation.
- Not defined: class 0 is an ordinary WRR member with weight cfg_weight[0 +: WWIDTH].

Test Plan:
- Reset/latency: release rst, push prior=3 data=0xA5 at cycle 10 with out_ready=1 -> out_valid high in cycle 12 only, out_data=0xA5, out_prior=3; all outputs 0 during reset.
- WRR ratio: weights c0=2, c1=1, others 1; preload 4 words each into prior 1 and 2; out_ready=1 -> out_prior order 1,1,2,1,1,2,2,2.
- Backpressure/full: QDEPTH=4, out_ready=0; push 5 words prior=2 -> first 4 accepted, in_ready=0 for the 5th; raise out_ready -> in_ready returns one cycle after the first pop; order is preserved.
- Drops: push prior=0 and prior=9 -> both accepted, neither output, drop_cnt=2; force drop_cnt to 0xFFFF, one more drop -> stays 0xFFFF.
- Output stall: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_prior unchanged, no FIFO pop; async reset asserted mid-stall -> out_valid=0 immediately.
- PRIO_SCHED_STRICT_EN: weights all 1, prior 2 and 3 queues full, inject prior=1 mid-stream -> it is the next output after the current word; rotation then resumes at the same pointer.

Source files
------------

// File: rtl/pkt_prio_sched.sv
// pkt_prio_sched: weighted round-robin scheduler draining per-class FIFOs
// into a single registered valid/ready egress port.
// Optional build macro PRIO_SCHED_STRICT_EN makes class 0 (prior 1)
// strict-priority and removes it from the round-robin rotation.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no rotation class holds data; next arrival restarts search
// S_SERVE | ptr_q is the class being served, credit_q pops remain
module pkt_prio_sched #(
   parameter int DWIDTH      = 32,
   parameter int PRIOR_WIDTH = 6,
   parameter int NUM_CLASS   = 7,
   parameter int QDEPTH      = 4,
   parameter int WWIDTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PRIOR_WIDTH-1:0]        in_prior,
   input  logic [DWIDTH-1:0]             in_data,
   input  logic [NUM_CLASS*WWIDTH-1:0]   cfg_weight,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DWIDTH-1:0]             out_data,
   output logic [PRIOR_WIDTH-1:0]        out_prior,
   output logic [15:0]                   drop_cnt
);

   localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
   localparam int AW = $clog2(QDEPTH);
   localparam int NW = AW + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SERVE = 1'b1;

`ifdef PRIO_SCHED_STRICT_EN
   localparam logic [NUM_CLASS-1:0] ROT_MASK = ~NUM_CLASS'(1);
`else
   localparam logic [NUM_CLASS-1:0] ROT_MASK = '1;
`endif

   logic [DWIDTH-1:0]      mem_q    [NUM_CLASS][QDEPTH];
   logic [AW-1:0]          wr_ptr_q [NUM_CLASS];
   logic [AW-1:0]          rd_ptr_q [NUM_CLASS];
   logic [NW-1:0]          cnt_q    [NUM_CLASS];
   logic [NW-1:0]          cnt_d    [NUM_CLASS];

   logic [NUM_CLASS-1:0]   full, nempty, rot_ne, rot_ne_d, push, pop;
   logic                   prior_ok, drop;
   logic [CW-1:0]          in_cls;

   logic [0:0]             state_q, state_d;
   logic [CW-1:0]          ptr_q, ptr_d;
   logic [WWIDTH-1:0]      credit_q, credit_d;

   logic                   load_en, strict_pop, wrr_pop, cand_vld, nxt_vld;
   logic [CW-1:0]          cand, nxt, pop_cls;
   logic [WWIDTH-1:0]      credit_use, credit_left;

   logic                   out_valid_q;
   logic [DWIDTH-1:0]      out_data_q;
   logic [PRIOR_WIDTH-1:0] out_prior_q;
   logic [15:0]            drop_cnt_q;

   // A weight of zero would stall a class forever, so it serves as one.
   function automatic logic [WWIDTH-1:0] eff_weight(
      input logic [NUM_CLASS*WWIDTH-1:0] wv,
      input logic [CW-1:0]               c
   );
      logic [WWIDTH-1:0] w;
      w = wv[int'(c)*WWIDTH +: WWIDTH];
      return (w == '0) ? WWIDTH'(1) : w;
   endfunction

   // Input decode: in_ready only looks at in_prior and FIFO occupancy.
   always_comb begin
      prior_ok = (in_prior != '0) && (int'(in_prior) <= NUM_CLASS);
      in_cls   = prior_ok ? CW'(int'(in_prior) - 1) : '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
         full[c]   = (cnt_q[c] == NW'(QDEPTH));
         nempty[c] = (cnt_q[c] != '0);
      end
      in_ready = prior_ok ? !full[in_cls] : 1'b1;
      push     = '0;
      if (in_valid && prior_ok && !full[in_cls])
         push[in_cls] = 1'b1;
      drop = in_valid && !prior_ok;
   end

   // Pick the class to serve: the current one while it has data,
   // otherwise the first non-empty class at or after the pointer.
   always_comb begin
      int idx;
      idx        = 0;
      rot_ne     = nempty & ROT_MASK;
      load_en    = !out_valid_q || out_ready;
`ifdef PRIO_SCHED_STRICT_EN
      strict_pop = load_en && nempty[0];
`else
      strict_pop = 1'b0;
`endif
      cand_vld = 1'b0;
      cand     = '0;
      for (int i = NUM_CLASS - 1; i >= 0; i--) begin
         idx = (int'(ptr_q) + i) % NUM_CLASS;
         if (rot_ne[idx]) begin
            cand_vld = 1'b1;
            cand     = CW'(idx);
         end
      end
      credit_use = (state_q == S_SERVE && cand == ptr_q) ? credit_q
                                                         : eff_weight(cfg_weight, cand);
      wrr_pop    = load_en && cand_vld && !strict_pop;
      pop_cls    = strict_pop ? '0 : cand;
      pop        = '0;
      if (strict_pop || wrr_pop)
         pop[pop_cls] = 1'b1;
   end

   // Next-cycle occupancy, used to decide where service goes after a pop.
   always_comb begin
      for (int c = 0; c < NUM_CLASS; c++) begin
         case ({push[c], pop[c]})
            2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
            2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
            default: cnt_d[c] = cnt_q[c];
         endcase
         rot_ne_d[c] = (cnt_d[c] != '0) && ROT_MASK[c];
      end
   end

   // Next class after the one just served, wrapping back to itself last.
   always_comb begin
      int idx;
      idx     = 0;
      nxt_vld = 1'b0;
      nxt     = '0;
      for (int i = NUM_CLASS; i >= 1; i--) begin
         idx = (int'(cand) + i) % NUM_CLASS;
         if (rot_ne_d[idx]) begin
            nxt_vld = 1'b1;
            nxt     = CW'(idx);
         end
      end
   end

   // Service FSM next state: credit bookkeeping and class switching.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      credit_d    = credit_q;
      credit_left = credit_use - 1'b1;
      if (cand_vld) begin
         if (wrr_pop) begin
            if (credit_left == '0 || !rot_ne_d[cand]) begin
               if (nxt_vld) begin
                  state_d  = S_SERVE;
                  ptr_d    = nxt;
                  credit_d = eff_weight(cfg_weight, nxt);
               end else begin
                  state_d  = S_IDLE;
                  ptr_d    = cand;
                  credit_d = '0;
               end
            end else begin
               state_d  = S_SERVE;
               ptr_d    = cand;
               credit_d = credit_left;
            end
         end else begin
            state_d  = S_SERVE;
            ptr_d    = cand;
            credit_d = credit_use;
         end
      end else begin
         state_d  = S_IDLE;
         credit_d = '0;
      end
   end

   // FSM registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CLASS; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CLASS; c++) begin
            if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
            if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   // FIFO storage; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CLASS; c++)
         if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data;
   end

   // Output register: loads on every opportunity, empties when nothing pops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_prior_q <= '0;
      end else if (load_en) begin
         if (strict_pop || wrr_pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[pop_cls][rd_ptr_q[pop_cls]];
            out_prior_q <= PRIOR_WIDTH'(int'(pop_cls) + 1);
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Saturating count of discarded words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 16'hFFFF)
         drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_prior = out_prior_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Bench for pkt_prio_sched: directed steps followed by randomized traffic,
// every cycle compared against a queue-based reference of the scheduler.
module tb_pkt_prio_sched;

   localparam int DW = 32;
   localparam int PW = 6;
   localparam int NC = 7;
   localparam int QD = 4;
   localparam int WW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [PW-1:0]     in_prior;
   logic [DW-1:0]     in_data;
   logic [NC*WW-1:0]  cfg_weight;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [PW-1:0]     out_prior;
   logic [15:0]       drop_cnt;

   always #5 clk = ~clk;

   pkt_prio_sched #(
      .DWIDTH(DW), .PRIOR_WIDTH(PW), .NUM_CLASS(NC), .QDEPTH(QD), .WWIDTH(WW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_prior(in_prior), .in_data(in_data),
      .cfg_weight(cfg_weight),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_prior(out_prior), .drop_cnt(drop_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   logic [DW-1:0] mq [NC][$];
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_op;
   int            m_ptr;
   int            m_credit;
   bit            m_serving;
   int            m_drop;

   // words consumed by the egress port, in order
   logic [DW-1:0] got_d [$];
   int            got_p [$];
   bit            last_rdy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wt(input int c);
      int w;
      w = int'(cfg_weight[c*WW +: WW]);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic bit in_rotation(input int c);
`ifdef PRIO_SCHED_STRICT_EN
      return (c != 0) && (mq[c].size() > 0);
`else
      return mq[c].size() > 0;
`endif
   endfunction

   function automatic int find_from(input int start);
      for (int i = 0; i < NC; i++)
         if (in_rotation((start + i) % NC)) return (start + i) % NC;
      return -1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_ov = 0; m_od = '0; m_op = 0;
      m_ptr = 0; m_credit = 0; m_serving = 0; m_drop = 0;
   endtask

   // One clock of scheduler behaviour, from the pre-edge view.
   task automatic model_step(input bit iv, input int pr, input logic [DW-1:0] dt,
                             input bit ordy, output bit rdy);
      bit ok, do_push, do_drop, load, popped;
      int cls, cand, cr, nx, pc;
      logic [DW-1:0] pd;
      ok      = (pr >= 1) && (pr <= NC);
      cls     = ok ? pr - 1 : 0;
      rdy     = ok ? (mq[cls].size() < QD) : 1'b1;
      do_push = iv && ok && rdy;
      do_drop = iv && !ok;
      load    = !m_ov || ordy;
      popped  = 0;
      pd      = '0;
      pc      = 0;
`ifdef PRIO_SCHED_STRICT_EN
      if (load && mq[0].size() > 0) begin
         pd = mq[0].pop_front(); pc = 0; popped = 1;
      end
`endif
      cand = find_from(m_ptr);
      if (cand >= 0) begin
         cr = (m_serving && cand == m_ptr) ? m_credit : wt(cand);
         if (load && !popped) begin
            pd = mq[cand].pop_front(); pc = cand; popped = 1;
            if (do_push) begin mq[cls].push_back(dt); do_push = 0; end
            cr--;
            if (cr == 0 || mq[cand].size() == 0) begin
               nx = find_from((cand + 1) % NC);
               if (nx >= 0) begin
                  m_ptr = nx; m_credit = wt(nx); m_serving = 1;
               end else begin
                  m_ptr = cand; m_credit = 0; m_serving = 0;
               end
            end else begin
               m_ptr = cand; m_credit = cr; m_serving = 1;
            end
         end else begin
            m_ptr = cand; m_credit = cr; m_serving = 1;
         end
      end else begin
         m_serving = 0;
      end
      if (do_push) mq[cls].push_back(dt);
      if (load) begin
         if (popped) begin m_ov = 1; m_od = pd; m_op = pc + 1; end
         else m_ov = 0;
      end
      if (do_drop && m_drop != 16'hFFFF) m_drop++;
   endtask

   // Apply inputs at the falling edge, clock once, compare at the next fall.
   task automatic drive(input bit iv, input int pr, input logic [DW-1:0] dt, input bit ordy);
      bit er;
      if (out_valid && ordy) begin
         got_d.push_back(out_data);
         got_p.push_back(int'(out_prior));
      end
      in_valid = iv; in_prior = PW'(pr); in_data = dt; out_ready = ordy;
      #1;
      last_rdy = in_ready;
      model_step(iv, pr, dt, ordy, er);
      check("in_ready", in_ready, er);
      @(posedge clk);
      @(negedge clk);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
         check("out_data", out_data, m_od);
         check("out_prior", out_prior, m_op);
      end
      check("drop_cnt", drop_cnt, m_drop);
   endtask

   initial begin
      int exp_wrr [8];
      logic [DW-1:0] hold_d;
      logic [PW-1:0] hold_p;
      int d0, inj;

      rst = 1'b0; in_valid = 0; in_prior = '0; in_data = '0; out_ready = 0;
      cfg_weight = {NC{4'd1}};
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 0);
      check("rst_out_prior", out_prior, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      rst = 1'b1;

      // latency: accepted at cycle 10, visible at cycle 12 only
      repeat (9) drive(0, 0, '0, 1);
      drive(1, 3, 32'hA5, 1);
      check("lat_t1_valid", out_valid, 1'b0);
      drive(0, 0, '0, 1);
      check("lat_t2_valid", out_valid, 1'b1);
      check("lat_t2_data", out_data, 32'hA5);
      check("lat_t2_prior", out_prior, 3);
      drive(0, 0, '0, 1);
      check("lat_t3_valid", out_valid, 1'b0);

      // weighted round robin, class 0 weight 2
      cfg_weight = {{(NC-1){4'd1}}, 4'd2};
      for (int i = 0; i < 4; i++) drive(1, 1, 32'h100 + i, 0);
      for (int i = 0; i < 4; i++) drive(1, 2, 32'h200 + i, 0);
      got_d.delete(); got_p.delete();
      for (int i = 0; i < 12; i++) drive(0, 0, '0, 1);
      exp_wrr = '{1, 1, 2, 1, 1, 2, 2, 2};
      check("wrr_count", got_p.size(), 8);
      for (int i = 0; i < 8 && i < got_p.size(); i++)
         check($sformatf("wrr_order[%0d]", i), got_p[i], exp_wrr[i]);

      // backpressure: output occupied, class 1 FIFO fills
      cfg_weight = {NC{4'd1}};
      drive(1, 3, 32'hCAFE, 0);
      drive(0, 0, '0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 2, 32'h300 + i, 0);
         check($sformatf("bp_accept[%0d]", i), last_rdy, 1'b1);
      end
      drive(1, 2, 32'h304, 0);
      check("bp_full", last_rdy, 1'b0);
      got_d.delete(); got_p.delete();
      drive(1, 2, 32'h304, 1);
      check("bp_no_bypass", last_rdy, 1'b0);
      drive(1, 2, 32'h304, 1);
      check("bp_reopen", last_rdy, 1'b1);
      for (int i = 0; i < 8; i++) drive(0, 0, '0, 1);
      check("bp_count", got_d.size(), 6);
      if (got_d.size() == 6) begin
         check("bp_first", got_d[0], 32'hCAFE);
         for (int i = 0; i < 5; i++)
            check($sformatf("bp_order[%0d]", i), got_d[i+1], 32'h300 + i);
      end

      // drops
      d0 = int'(drop_cnt);
      got_d.delete(); got_p.delete();
      drive(1, 0, 32'hDEAD, 1);
      check("drop0_ready", last_rdy, 1'b1);
      drive(1, 9, 32'hBEEF, 1);
      check("drop9_ready", last_rdy, 1'b1);
      repeat (3) drive(0, 0, '0, 1);
      check("drop_cnt2", drop_cnt, d0 + 2);
      check("drop_no_out", got_d.size(), 0);

      // output stall then asynchronous reset mid-stall
      drive(1, 4, 32'h4444, 0);
      drive(1, 5, 32'h5550, 0);
      drive(1, 5, 32'h5551, 0);
      hold_d = out_data; hold_p = out_prior;
      check("stall_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, '0, 0);
         check($sformatf("stall_data[%0d]", i), out_data, 32'h4444);
         check($sformatf("stall_prior[%0d]", i), out_prior, 4);
      end
      check("stall_hold_d", out_data, hold_d);
      check("stall_hold_p", out_prior, hold_p);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_data", out_data, 0);
      check("arst_drop", drop_cnt, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) drive(0, 0, '0, 1);
      check("arst_no_partial", out_valid, 1'b0);

      // randomized traffic with occasional weight changes
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) cfg_weight = (NC*WW)'({$urandom, $urandom});
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(1, NC),
               $urandom, $urandom_range(0, 9) < 7);
      end
      repeat (40) drive(0, 0, '0, 1);

`ifdef PRIO_SCHED_STRICT_EN
      // strict class 0 jumps ahead of a busy rotation
      cfg_weight = {NC{4'd1}};
      for (int i = 0; i < 4; i++) drive(1, 2, 32'h600 + i, 0);
      for (int i = 0; i < 4; i++) drive(1, 3, 32'h700 + i, 0);
      got_d.delete(); got_p.delete();
      drive(0, 0, '0, 1);
      drive(0, 0, '0, 1);
      inj = got_p.size();
      drive(1, 1, 32'h5A5A, 1);
      for (int i = 0; i < 12; i++) drive(0, 0, '0, 1);
      check("strict_next", (got_p.size() > inj + 2) ? got_p[inj+2] : -1, 1);
      check("strict_data", (got_d.size() > inj + 2) ? got_d[inj+2] : '0, 32'h5A5A);
`endif

      // drop counter saturation
      for (int i = 0; i < 70000 && m_drop < 16'hFFFF; i++) drive(1, 0, '0, 1);
      repeat (3) drive(1, NC + 1, '0, 1);
      check("drop_saturate", drop_cnt, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
